// File: rtl/dac_ring_ctrl_pkg.sv
// Shared constants, state encoding and write-beat payload for the DAC ring-buffer controller.
package dac_ring_ctrl_pkg;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned HALF_BYTES = 1024;
    localparam int unsigned HALF_W     = ADDR_W - 1;
    localparam int unsigned FREE_W     = 2;
    localparam int unsigned FREE_MAX   = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        PLAY     = 2'd2,
        UNDERRUN = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_beat_t;

    // States in which the DAC is running and its status bit is meaningful.
    function automatic logic is_playing(state_t s);
        return (s == PLAY) || (s == UNDERRUN);
    endfunction

endpackage

// File: rtl/dac_ring_ctrl_if.sv
// MCU, streamer and DAC buffer-port signals; master = controller side, slave = environment side.
interface dac_ring_ctrl_if;

    logic                                  mcu_req;
    logic [dac_ring_ctrl_pkg::ADDR_W-1:0]  mcu_addr;
    logic [dac_ring_ctrl_pkg::DATA_W-1:0]  mcu_data;
    logic                                  mcu_gnt;
    logic                                  st_valid;
    logic [dac_ring_ctrl_pkg::DATA_W-1:0]  st_data;
    logic                                  st_ready;
    logic                                  dac_we_n;
    logic [dac_ring_ctrl_pkg::ADDR_W-1:0]  dac_addr;
    logic [dac_ring_ctrl_pkg::DATA_W-1:0]  dac_data;
    logic                                  dac_play;
    logic                                  dac_reset;
    logic                                  dac_status;

    modport master (
        input  mcu_req, mcu_addr, mcu_data, st_valid, st_data, dac_status,
        output mcu_gnt, st_ready, dac_we_n, dac_addr, dac_data, dac_play, dac_reset
    );

    modport slave (
        output mcu_req, mcu_addr, mcu_data, st_valid, st_data, dac_status,
        input  mcu_gnt, st_ready, dac_we_n, dac_addr, dac_data, dac_play, dac_reset
    );

endinterface

// File: rtl/dac_wr_arb.sv
// Two-way round-robin arbiter for the buffer write port; on contention the last winner loses.
module dac_wr_arb (
    input  logic clkin,
    input  logic reset_n,
    input  logic en,
    input  logic mcu_req,
    input  logic st_en,
    input  logic st_valid,
    output logic mcu_gnt,
    output logic st_grant
);

    logic last_st;
    logic st_act;

    // st_grant depends only on enables and mcu_req so the streamer sees a valid-independent ready.
    always_comb begin
        st_act   = st_en && st_valid;
        st_grant = st_en && (!mcu_req || !last_st);
        mcu_gnt  = en && mcu_req && (!st_act || last_st);
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            last_st <= 1'b1;
        end else if (st_act && st_grant) begin
            last_st <= 1'b1;
        end else if (mcu_gnt) begin
            last_st <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_ring_ctrl.sv
// DAC ring-buffer sequencer: shares the write port, primes/starts playback, tracks free halves.
// Build option DACCTL_UNDERRUN_STOP_EN: an underrun event returns the controller to IDLE.
module dac_ring_ctrl
    import dac_ring_ctrl_pkg::*;
(
    input  logic              clkin,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    dac_ring_ctrl_if.master   bus,
    output logic              refill_irq,
    output logic              underrun,
    output logic [FREE_W-1:0] free_halves
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [FREE_W-1:0] free_nxt;
    logic              underrun_nxt;
    logic              status_d;
    logic              status_edge;
    logic              half_done;
    logic              ur_event;
    logic              active;
    logic              st_en;
    logic              mcu_gnt;
    logic              st_grant;
    logic              st_xfer;
    logic              wr_en;
    logic              playing_nxt;
    wr_beat_t          beat;

    assign active = (state != IDLE);
    assign st_en  = active && (free_halves != '0);

    dac_wr_arb u_arb (
        .clkin    (clkin),
        .reset_n  (reset_n),
        .en       (active),
        .mcu_req  (bus.mcu_req),
        .st_en    (st_en),
        .st_valid (bus.st_valid),
        .mcu_gnt  (mcu_gnt),
        .st_grant (st_grant)
    );

    assign bus.mcu_gnt  = mcu_gnt;
    assign bus.st_ready = st_grant;

    // Next-state, pointer, free-count and underrun bookkeeping.
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        free_nxt     = free_halves;
        underrun_nxt = underrun;

        st_xfer     = st_grant && bus.st_valid;
        wr_en       = mcu_gnt || st_xfer;
        half_done   = st_xfer && (wr_ptr[HALF_W-1:0] == HALF_W'(HALF_BYTES - 1));
        status_edge = is_playing(state) && (bus.dac_status != status_d);
        // A half completed in the same cycle counts as filled before the DAC arrives.
        ur_event    = status_edge && ((free_halves - FREE_W'(half_done)) != '0);

        if (mcu_gnt) begin
            beat.addr = bus.mcu_addr;
            beat.data = bus.mcu_data;
        end else begin
            beat.addr = wr_ptr;
            beat.data = bus.st_data;
        end

        if (st_xfer) begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
        end

        if (status_edge && !half_done) begin
            if (free_halves != FREE_W'(FREE_MAX)) begin
                free_nxt = free_halves + FREE_W'(1);
            end
        end else if (half_done && !status_edge) begin
            free_nxt = free_halves - FREE_W'(1);
        end

        if (ur_event) begin
            underrun_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = PRIME;
                    underrun_nxt = 1'b0;
                end
            end
            PRIME: begin
                if (free_halves == '0) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (ur_event) begin
                    state_nxt = UNDERRUN;
                end
            end
            default: ;
        endcase

`ifdef DACCTL_UNDERRUN_STOP_EN
        if (ur_event) begin
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
            free_nxt   = FREE_W'(FREE_MAX);
        end
`endif

        if (stop) begin
            state_nxt    = IDLE;
            wr_ptr_nxt   = '0;
            free_nxt     = FREE_W'(FREE_MAX);
            underrun_nxt = 1'b0;
        end

        playing_nxt = is_playing(state_nxt);
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            free_halves <= FREE_W'(FREE_MAX);
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            free_halves <= free_nxt;
            underrun    <= underrun_nxt;
        end
    end

    // Registered buffer strobe, DAC control and status history.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            bus.dac_we_n  <= 1'b1;
            bus.dac_addr  <= '0;
            bus.dac_data  <= '0;
            bus.dac_play  <= 1'b0;
            bus.dac_reset <= 1'b1;
            refill_irq    <= 1'b0;
            status_d      <= 1'b0;
        end else begin
            bus.dac_we_n  <= !wr_en;
            if (wr_en) begin
                bus.dac_addr <= beat.addr;
                bus.dac_data <= beat.data;
            end
            bus.dac_play  <= playing_nxt;
            bus.dac_reset <= !playing_nxt;
            refill_irq    <= status_edge;
            status_d      <= bus.dac_status;
        end
    end

endmodule

// File: tb/tb_dac_ring_ctrl.sv
// Self-checking bench for dac_ring_ctrl: vector table, directed corner sequences, random traffic.
module tb_dac_ring_ctrl;

    localparam int unsigned AW = dac_ring_ctrl_pkg::ADDR_W;
    localparam int unsigned DW = dac_ring_ctrl_pkg::DATA_W;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_PLAY  = 2;
    localparam int M_UR    = 3;

    logic       clkin = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       refill_irq;
    logic       underrun;
    logic [1:0] free_halves;

    dac_ring_ctrl_if bus();

    dac_ring_ctrl dut (
        .clkin       (clkin),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .bus         (bus),
        .refill_irq  (refill_irq),
        .underrun    (underrun),
        .free_halves (free_halves)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    // Reference model: playback mode, bytes streamed since start, free halves, sticky underrun.
    int m_mode, m_bytes, m_free;
    bit m_ur, m_last_st, m_stat_prev;
    int e_we_n, e_addr, e_data, e_irq;
    bit d_mg, d_sx, cur_stat;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(bit st, bit sp, bit mr, int ma, int md, bit sv, int sd, bit stat);
        bit act, st_ok, mg, sg, hd, edg, urev;
        int ptr, nfree, nmode;
        @(negedge clkin);
        start = st; stop = sp;
        bus.mcu_req = mr; bus.mcu_addr = AW'(ma); bus.mcu_data = DW'(md);
        bus.st_valid = sv; bus.st_data = DW'(sd); bus.dac_status = stat;
        #1;
        act   = (m_mode != M_IDLE);
        st_ok = act && (m_free > 0);
        if (!act) begin
            mg = 0; sg = 0;
        end else if (mr && sv && st_ok) begin
            sg = !m_last_st; mg = m_last_st;
        end else begin
            mg = mr; sg = sv && st_ok;
        end
        d_mg = bus.mcu_gnt;
        d_sx = bus.st_ready && sv;
        chk("mcu_gnt", int'(d_mg), int'(mg));
        chk("st_xfer", int'(d_sx), int'(sg));
        ptr  = m_bytes % 2048;
        hd   = sg && ((ptr % 1024) == 1023);
        edg  = (m_mode == M_PLAY || m_mode == M_UR) && (stat != m_stat_prev);
        urev = edg && ((m_free - int'(hd)) > 0);
        nfree = m_free;
        if (edg && !hd) nfree = (m_free < 2) ? m_free + 1 : 2;
        else if (hd && !edg) nfree = m_free - 1;
        if (mg || sg) begin
            e_we_n = 0; e_addr = mg ? ma : ptr; e_data = mg ? md : sd;
        end else begin
            e_we_n = 1;
        end
        if (sg) m_bytes++;
        if (sg) m_last_st = 1; else if (mg) m_last_st = 0;
        if (urev) m_ur = 1;
        nmode = m_mode;
        if (m_mode == M_IDLE && st) begin
            nmode = M_PRIME; m_ur = 0;
        end else if (m_mode == M_PRIME && m_free == 0) begin
            nmode = M_PLAY;
        end else if (m_mode == M_PLAY && urev) begin
            nmode = M_UR;
        end
`ifdef DACCTL_UNDERRUN_STOP_EN
        if (urev) begin nmode = M_IDLE; m_bytes = 0; nfree = 2; end
`endif
        if (sp) begin nmode = M_IDLE; m_bytes = 0; nfree = 2; m_ur = 0; end
        m_mode = nmode; m_free = nfree; m_stat_prev = stat; e_irq = int'(edg);
        @(posedge clkin);
        #1;
        chk("dac_we_n", int'(bus.dac_we_n), e_we_n);
        if (e_we_n == 0) begin
            chk("dac_addr", int'(bus.dac_addr), e_addr);
            chk("dac_data", int'(bus.dac_data), e_data);
        end
        chk("dac_play", int'(bus.dac_play), int'(m_mode == M_PLAY || m_mode == M_UR));
        chk("dac_reset", int'(bus.dac_reset), int'(!(m_mode == M_PLAY || m_mode == M_UR)));
        chk("refill_irq", int'(refill_irq), e_irq);
        chk("underrun", int'(underrun), int'(m_ur));
        chk("free_halves", int'(free_halves), m_free);
    endtask

    task automatic idle_cyc();
        cycle(0, 0, 0, 0, 0, 0, 0, cur_stat);
    endtask

    task automatic stream(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1, int'($urandom_range(0, 255)), cur_stat);
    endtask

    typedef struct {
        bit st, sp, mr; int ma, md; bit sv; int sd;
        bit x_mg, x_sx, x_we_n; int x_addr, x_data, x_free;
    } vec_t;
    vec_t tbl[9];

    initial begin
        bit mr, sv, sp, st;
        int ma, md, k;
        int pat[4];

        tbl[0] = '{0,0,1,'h010,'h11,0,0,     0,0,1,-1,-1,2};  // IDLE: no grants
        tbl[1] = '{1,0,0,0,0,0,0,            0,0,1,-1,-1,2};  // start -> PRIME
        tbl[2] = '{0,0,0,0,0,1,'hA1,         0,1,0,0,'hA1,2};
        tbl[3] = '{0,0,1,'h400,'h5C,1,'hB2,  1,0,0,'h400,'h5C,2};
        tbl[4] = '{0,0,1,'h400,'h5D,1,'hB2,  0,1,0,1,'hB2,2};
        tbl[5] = '{0,0,0,0,0,0,0,            0,0,1,-1,-1,2};
        tbl[6] = '{1,1,0,0,0,0,0,            0,0,1,-1,-1,2};  // stop beats start
        tbl[7] = '{0,0,0,0,0,1,'h33,         0,0,1,-1,-1,2};
        tbl[8] = '{0,0,1,'h7FF,'hEE,0,0,     0,0,1,-1,-1,2};

        reset_n = 0; start = 0; stop = 0;
        bus.mcu_req = 1; bus.mcu_addr = '0; bus.mcu_data = '0;
        bus.st_valid = 1; bus.st_data = '0; bus.dac_status = 0;
        repeat (3) @(negedge clkin);
        #1;
        chk("rst_we_n", int'(bus.dac_we_n), 1);
        chk("rst_addr", int'(bus.dac_addr), 0);
        chk("rst_data", int'(bus.dac_data), 0);
        chk("rst_play", int'(bus.dac_play), 0);
        chk("rst_dac_reset", int'(bus.dac_reset), 1);
        chk("rst_mcu_gnt", int'(bus.mcu_gnt), 0);
        chk("rst_st_ready", int'(bus.st_ready), 0);
        chk("rst_irq", int'(refill_irq), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_free", int'(free_halves), 2);
        bus.mcu_req = 0; bus.st_valid = 0;
        @(negedge clkin);
        reset_n = 1;
        m_mode = M_IDLE; m_bytes = 0; m_free = 2; m_ur = 0; m_last_st = 1; m_stat_prev = 0;
        cur_stat = 0;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].st, tbl[i].sp, tbl[i].mr, tbl[i].ma, tbl[i].md, tbl[i].sv, tbl[i].sd, 0);
            chk($sformatf("tbl%0d_mg", i), int'(d_mg), int'(tbl[i].x_mg));
            chk($sformatf("tbl%0d_sx", i), int'(d_sx), int'(tbl[i].x_sx));
            chk($sformatf("tbl%0d_we_n", i), int'(bus.dac_we_n), int'(tbl[i].x_we_n));
            if (tbl[i].x_addr >= 0) begin
                chk($sformatf("tbl%0d_addr", i), int'(bus.dac_addr), tbl[i].x_addr);
                chk($sformatf("tbl%0d_data", i), int'(bus.dac_data), tbl[i].x_data);
            end
            chk($sformatf("tbl%0d_free", i), int'(free_halves), tbl[i].x_free);
        end

        // Prime the whole buffer, then playback starts
        cycle(1, 0, 0, 0, 0, 0, 0, cur_stat);
        for (int i = 0; i < 2048; i++) begin
            stream(1);
            chk("prime_dac_reset", int'(bus.dac_reset), 1);
        end
        chk("prime_free0", int'(free_halves), 0);
        idle_cyc();
        chk("prime_play", int'(bus.dac_play), 1);

        // Refill one half
        cur_stat = 1;
        idle_cyc();
        chk("refill_irq_pulse", int'(refill_irq), 1);
        chk("refill_free1", int'(free_halves), 1);
        idle_cyc();
        chk("refill_irq_single", int'(refill_irq), 0);
        stream(1);
        chk("refill_addr0", int'(bus.dac_addr), 0);
        stream(1023);
        chk("refill_free0", int'(free_halves), 0);

        // Two status toggles without refill
        cur_stat = 0;
        idle_cyc();
        chk("ur_first_edge", int'(underrun), 0);
        idle_cyc();
        cur_stat = 1;
        idle_cyc();
        chk("ur_second_edge", int'(underrun), 1);
`ifdef DACCTL_UNDERRUN_STOP_EN
        chk("ur_stop_play", int'(bus.dac_play), 0);
`else
        chk("ur_keep_play", int'(bus.dac_play), 1);
`endif
        chk("ur_free2", int'(free_halves), 2);

        // Status edge coinciding with completion of the half at 1023
        cycle(0, 1, 0, 0, 0, 0, 0, cur_stat);
        cycle(1, 0, 0, 0, 0, 0, 0, cur_stat);
        stream(2048);
        idle_cyc();
        cur_stat = !cur_stat;
        idle_cyc();
        stream(1023);
        cur_stat = !cur_stat;
        cycle(0, 0, 0, 0, 0, 1, 'h5A, cur_stat);
        chk("coinc_addr", int'(bus.dac_addr), 1023);
        chk("coinc_free", int'(free_halves), 1);
        chk("coinc_no_ur", int'(underrun), 0);
        chk("coinc_irq", int'(refill_irq), 1);

        // Round-robin under sustained contention
        cycle(0, 1, 0, 0, 0, 0, 0, cur_stat);
        cycle(1, 0, 0, 0, 0, 0, 0, cur_stat);
        k = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 'h100 + k, 'h40 + k, 1, 'h80 + i, cur_stat);
            pat[i] = int'(d_mg);
            if (d_mg) k++;
            chk("rr_we_n", int'(bus.dac_we_n), 0);
        end
        chk("rr_g0_mcu", pat[0], 1);
        chk("rr_g1_st", pat[1], 0);
        chk("rr_g2_mcu", pat[2], 1);
        chk("rr_g3_st", pat[3], 0);

        // Stop in the middle of priming, then restart from address 0
        stream(298);
        cycle(0, 1, 0, 0, 0, 0, 0, cur_stat);
        chk("stop_free2", int'(free_halves), 2);
        chk("stop_play", int'(bus.dac_play), 0);
        cycle(1, 0, 0, 0, 0, 0, 0, cur_stat);
        stream(1);
        chk("restart_addr0", int'(bus.dac_addr), 0);

        // Random traffic against the model
        mr = 0; ma = 0; md = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!mr || d_mg) begin
                mr = ($urandom_range(0, 3) == 0);
                ma = int'($urandom_range(0, 2047));
                md = int'($urandom_range(0, 255));
            end
            sv = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 99) == 0);
            sp = !mr && ($urandom_range(0, 1499) == 0);
            if (sp) sv = 0;
            if ($urandom_range(0, 299) == 0) cur_stat = !cur_stat;
            cycle(st, sp, mr, ma, md, sv, int'($urandom_range(0, 255)), cur_stat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
